sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single SRAM controller port between two cache requesters: port 0 is the instruction cache, port 1 is the data cache.
- Accepts full-line requests from each side using the cache valid/ready convention.
- Serialises the requests onto the memory side with round-robin fairness and returns read data to the winning requester only.
- Includes a watchdog that flags a memory side that never answers.

Parameters:
- ADDR_W, 20: address width on every port.
- DATA_W, 64: line data width on every port.
- TIMEOUT, 255: maximum cycles spent in WAIT before err_timeout is raised. Legal range is 1..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- r0_valid / r1_valid  in  1  request pending. Held high until the matching rN_ready.
- r0_rw / r1_rw  in  1  1 = write, 0 = read.
- r0_addr / r1_addr  in  ADDR_W  line address.
- r0_wdata / r1_wdata  in  DATA_W  write data.
- r0_ready / r1_ready  out  1  one-cycle completion pulse.
- r0_rdata / r1_rdata  out  DATA_W  read data. Valid only while the matching rN_ready is high.
- m_valid  out  1  request to the SRAM controller. One-cycle pulse.
- m_rw  out  1  latched direction.
- m_addr  out  ADDR_W  latched address.
- m_wdata  out  DATA_W  latched write data.
- m_ready  in  1  completion from the SRAM controller.
- m_rdata  in  DATA_W  read data from the SRAM controller. Sampled when m_ready=1.
- grant  out  1  index of the requester currently owning memory.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky watchdog flag.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, last_grant=1 (so port 0 wins first), all outputs 0, wait counter=0. Reset also aborts any transaction in flight:
  - no rN_ready is issued for it;
  - m_valid stays 0 in the following cycle.
- State machine, all outputs registered:
  - IDLE: sample r0_valid/r1_valid.
    - Only one valid: grant it.
    - Both valid: grant the port opposite last_grant.
    - On a grant: latch rw/addr/wdata into the hold register, set grant, go to ISSUE.
  - ISSUE: m_valid=1 for exactly this one cycle; m_rw/m_addr/m_wdata come from the hold register. Go to WAIT and clear the wait counter.
  - WAIT:
    - m_valid=0. m_rw/m_addr/m_wdata stay stable at the hold values for the whole transaction.
    - Counter increments every cycle.
    - On m_ready=1: capture m_rdata, set last_grant=grant, go to RESP.
  - RESP: r[grant]_ready=1 for one cycle and r[grant]_rdata=captured data. The other port's ready stays 0. Go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> m_valid at cycle 1 -> m_ready earliest at cycle 2 -> rN_ready one cycle after m_ready. The minimum request-to-ready time is 3 cycles.
- A requester that drops valid before its ready (protocol violation) does not abort the transaction. It still completes and is acknowledged.
- m_ready outside WAIT is ignored.
- Write completion: rN_ready pulses and rN_rdata holds the last captured value. The content of rN_rdata on writes is don't-care.
- The rdata outputs of the port that is not acknowledged hold their previous value.
- Watchdog:
  - If the wait counter reaches TIMEOUT while still in WAIT, err_timeout<=1 (sticky).
  - The FSM keeps waiting; there is no forced completion.
  - The counter saturates at TIMEOUT.
- err_clr=1 clears err_timeout in the next cycle. If a new timeout fires in the same cycle as err_clr, the set wins.
- busy=1 in ISSUE, WAIT and RESP.
- Fairness: when both ports are continuously requesting, grants alternate strictly 0,1,0,1.
- A requester that has been served can be granted again no earlier than its next IDLE visit, after the other pending port has been served.

Test Plan:
- Single read on port 0: r0_valid, rw=0, addr=0x00010; m_ready after 2 WAIT cycles with m_rdata=0xDEADBEEF_CAFEF00D -> m_valid pulses exactly once with m_addr=0x00010. r0_ready pulses once with that data. r1_ready stays 0.
- Simultaneous requests: r0 read 0x00020 and r1 write 0x00030 with wdata=0x1122334455667788, both asserted from reset -> port 0 is served first, then port 1. m_wdata=0x1122334455667788 during port 1's ISSUE. Grant order is 0,1.
- Back-to-back contention: both ports hold valid for 4 transactions each -> grant sequence is 0,1,0,1,... There are never two m_valid pulses without an intervening m_ready.
- Spurious m_ready: m_ready=1 while in IDLE and in ISSUE -> no rN_ready and no state change.
- Timeout: TIMEOUT=8, m_ready withheld -> err_timeout=1 on the 8th WAIT cycle and stays high. A later m_ready still completes the transaction. err_clr then clears the flag.
- Reset mid-WAIT: assert rst with r1 outstanding -> next cycle is IDLE with all outputs 0, and no r1_ready. The next grant goes to port 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter sharing one SRAM controller port between the
// instruction cache (port 0) and data cache (port 1), with a stall watchdog.
module sram_arbiter #(
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   input  logic              r0_rw,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ready,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_valid,
   input  logic              r1_rw,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ready,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              m_valid,
   output logic              m_rw,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ready,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              grant,
   output logic              busy,
   output logic              err_timeout,
   input  logic              err_clr
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sel;
   logic               grant_d, busy_d, err_d;
   logic               m_valid_d, m_rw_d;
   logic [ADDR_W-1:0]  m_addr_d;
   logic [DATA_W-1:0]  m_wdata_d;
   logic               r0_ready_d, r1_ready_d;
   logic [DATA_W-1:0]  r0_rdata_d, r1_rdata_d;

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      sel          = 1'b0;
      grant_d      = grant;
      m_valid_d    = 1'b0;
      m_rw_d       = m_rw;
      m_addr_d     = m_addr;
      m_wdata_d    = m_wdata;
      r0_ready_d   = 1'b0;
      r1_ready_d   = 1'b0;
      r0_rdata_d   = r0_rdata;
      r1_rdata_d   = r1_rdata;
      err_d        = err_clr ? 1'b0 : err_timeout;

      case (state_q)
         IDLE: begin
            if (r0_valid || r1_valid) begin
               // Contention goes to the port that was not served last.
               sel       = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
               grant_d   = sel;
               m_rw_d    = sel ? r1_rw    : r0_rw;
               m_addr_d  = sel ? r1_addr  : r0_addr;
               m_wdata_d = sel ? r1_wdata : r0_wdata;
               m_valid_d = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d = 1'b1;
            end
            if (m_ready) begin
               if (grant) begin
                  r1_rdata_d = m_rdata;
                  r1_ready_d = 1'b1;
               end else begin
                  r0_rdata_d = m_rdata;
                  r0_ready_d = 1'b1;
               end
               last_grant_d = grant;
               state_d      = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         grant        <= 1'b0;
         busy         <= 1'b0;
         err_timeout  <= 1'b0;
         m_valid      <= 1'b0;
         m_rw         <= 1'b0;
         m_addr       <= '0;
         m_wdata      <= '0;
         r0_ready     <= 1'b0;
         r1_ready     <= 1'b0;
         r0_rdata     <= '0;
         r1_rdata     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         grant        <= grant_d;
         busy         <= busy_d;
         err_timeout  <= err_d;
         m_valid      <= m_valid_d;
         m_rw         <= m_rw_d;
         m_addr       <= m_addr_d;
         m_wdata      <= m_wdata_d;
         r0_ready     <= r0_ready_d;
         r1_ready     <= r1_ready_d;
         r0_rdata     <= r0_rdata_d;
         r1_rdata     <= r1_rdata_d;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a transaction-timeline model.
module tb_sram_arbiter;

   localparam int unsigned AW = 20;
   localparam int unsigned DW = 64;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          r0_valid, r0_rw, r0_ready;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata, r0_rdata;
   logic          r1_valid, r1_rw, r1_ready;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata, r1_rdata;
   logic          m_valid, m_rw, m_ready;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic          grant, busy, err_timeout, err_clr;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ready(r0_ready), .r0_rdata(r0_rdata),
      .r1_valid(r1_valid), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ready(r1_ready), .r1_rdata(r1_rdata),
      .m_valid(m_valid), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata),
      .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: each port holds at most one request; a grant at cycle g gives
   // m_valid at g+1, m_ready at g+2+d, ready at g+3+d, memory free at g+4+d.
   int            n = 0;
   bit [1:0]      pend;
   bit            q_rw   [2];
   logic [AW-1:0] q_addr [2];
   logic [DW-1:0] q_wd   [2];
   int            owner;
   int            t_issue, t_mr, t_resp, free_at;
   bit            last;
   bit            exp_gnt, exp_rw, err_exp;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wd, rsp_d;
   int            glog[$];
   int            mv_cnt;

   bit            auto_req, spur, rst_req, clr_req, use_fdata;
   int            req_pct;
   int            force_dly;
   logic [DW-1:0] fdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   task automatic model_reset();
      owner    = -1;
      pend     = 2'b00;
      last     = 1'b1;
      exp_gnt  = 1'b0;
      exp_rw   = 1'b0;
      exp_addr = '0;
      exp_wd   = '0;
      err_exp  = 1'b0;
      free_at  = n + 1;
      t_issue  = 0;
      t_mr     = 0;
      t_resp   = 0;
   endtask

   task automatic want(input int p, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      pend[p]   = 1'b1;
      q_rw[p]   = rw;
      q_addr[p] = a;
      q_wd[p]   = wd;
   endtask

   // One cycle: check the outputs of cycle n, then drive the inputs of cycle n.
   task automatic step();
      int  d;
      bit  set_c;
      @(negedge clk);
      n++;
      if (owner >= 0 && n == t_issue) begin
         exp_gnt  = (owner == 1);
         exp_rw   = q_rw[owner];
         exp_addr = q_addr[owner];
         exp_wd   = q_wd[owner];
         glog.push_back(int'(grant));
      end
      if (m_valid) mv_cnt++;

      chk("m_valid",  64'(m_valid),  64'(owner >= 0 && n == t_issue));
      chk("busy",     64'(busy),     64'(owner >= 0 && n >= t_issue && n <= t_resp));
      chk("r0_ready", 64'(r0_ready), 64'(owner == 0 && n == t_resp));
      chk("r1_ready", 64'(r1_ready), 64'(owner == 1 && n == t_resp));
      chk("grant",    64'(grant),    64'(exp_gnt));
      chk("m_rw",     64'(m_rw),     64'(exp_rw));
      chk("m_addr",   64'(m_addr),   64'(exp_addr));
      chk("m_wdata",  m_wdata,       exp_wd);
      chk("err",      64'(err_timeout), 64'(err_exp));
      if (owner >= 0 && n == t_resp && !q_rw[owner])
         chk(owner == 0 ? "r0_rdata" : "r1_rdata", owner == 0 ? r0_rdata : r1_rdata, rsp_d);

      if (owner >= 0 && n == t_resp) begin
         last        = (owner == 1);
         pend[owner] = 1'b0;
         owner       = -1;
      end

      m_rdata = {$urandom, $urandom};
      err_clr = 1'b0;
      if (rst_req) begin
         rst      = 1'b1;
         rst_req  = 1'b0;
         m_ready  = 1'b0;
         r0_valid = 1'b0;
         r1_valid = 1'b0;
         model_reset();
         return;
      end
      rst = 1'b0;

      for (int p = 0; p < 2; p++) begin
         if (!pend[p] && auto_req && ($urandom % 100) < req_pct)
            want(p, 1'($urandom), AW'($urandom), {$urandom, $urandom});
      end
      r0_valid = pend[0]; r0_rw = q_rw[0]; r0_addr = q_addr[0]; r0_wdata = q_wd[0];
      r1_valid = pend[1]; r1_rw = q_rw[1]; r1_addr = q_addr[1]; r1_wdata = q_wd[1];

      if (owner < 0 && n >= free_at && pend != 2'b00) begin
         owner   = (pend == 2'b11) ? (last ? 0 : 1) : (pend[0] ? 0 : 1);
         d       = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 5));
         t_issue = n + 1;
         t_mr    = n + 2 + d;
         t_resp  = t_mr + 1;
         free_at = t_resp + 1;
         rsp_d   = use_fdata ? fdata : {$urandom, $urandom};
      end

      if (owner >= 0 && n == t_mr) begin
         m_ready = 1'b1;
         m_rdata = rsp_d;
      end else if (owner >= 0 && n > t_issue && n < t_mr) begin
         m_ready = 1'b0;
      end else begin
         m_ready = spur ? 1'($urandom) : 1'b0;
      end

      err_clr = clr_req;
      clr_req = 1'b0;
      set_c   = (owner >= 0 && n == t_issue + int'(TO) && t_mr >= n);
      err_exp = (err_clr ? 1'b0 : err_exp) | set_c;
   endtask

   task automatic run_until_idle(input int budget);
      int k = 0;
      while ((owner >= 0 || pend != 2'b00) && k < budget) begin
         step();
         k++;
      end
      chk("drain_budget", 64'(owner >= 0 || pend != 2'b00), 64'(0));
   endtask

   initial begin
      int base, k;
      rst = 1'b1; err_clr = 1'b0; m_ready = 1'b0; m_rdata = '0;
      r0_valid = 1'b0; r0_rw = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_valid = 1'b0; r1_rw = 1'b0; r1_addr = '0; r1_wdata = '0;
      auto_req = 1'b0; spur = 1'b0; clr_req = 1'b0; use_fdata = 1'b0;
      req_pct = 0; force_dly = -1; fdata = '0; mv_cnt = 0;
      q_rw[0] = 1'b0; q_rw[1] = 1'b0; q_addr[0] = '0; q_addr[1] = '0; q_wd[0] = '0; q_wd[1] = '0;
      model_reset();
      repeat (2) @(posedge clk);
      rst_req = 1'b1;
      step();
      step();

      // Single read on port 0, answered on the third WAIT cycle.
      force_dly = 2; use_fdata = 1'b1; fdata = 64'hDEADBEEF_CAFEF00D;
      mv_cnt = 0;
      want(0, 1'b0, AW'(20'h00010), '0);
      run_until_idle(50);
      step();
      chk("t1_mvalid_count", 64'(mv_cnt), 64'(1));
      chk("t1_r0_rdata", r0_rdata, 64'hDEADBEEF_CAFEF00D);
      use_fdata = 1'b0; force_dly = -1;

      // Simultaneous requests straight out of reset: port 0 first.
      rst_req = 1'b1;
      step();
      want(0, 1'b0, AW'(20'h00020), '0);
      want(1, 1'b1, AW'(20'h00030), 64'h1122334455667788);
      base = glog.size();
      run_until_idle(100);
      chk("t2_grants", 64'(glog.size() - base), 64'(2));
      if (glog.size() - base == 2) begin
         chk("t2_first", 64'(glog[base]), 64'(0));
         chk("t2_second", 64'(glog[base + 1]), 64'(1));
      end

      // Continuous contention: strict alternation starting at port 0.
      auto_req = 1'b1; req_pct = 100;
      base = glog.size();
      k = 0;
      while (glog.size() < base + 8 && k < 500) begin
         step();
         k++;
      end
      auto_req = 1'b0;
      run_until_idle(100);
      chk("t3_count", 64'(glog.size() >= base + 8), 64'(1));
      if (glog.size() >= base + 8)
         for (int i = 0; i < 8; i++) chk("t3_alternate", 64'(glog[base + i]), 64'(i % 2));

      // Random traffic with spurious m_ready outside WAIT.
      spur = 1'b1; auto_req = 1'b1; req_pct = 30;
      repeat (400) step();
      auto_req = 1'b0;
      run_until_idle(100);
      spur = 1'b0;

      // Watchdog: stalled memory, clear colliding with the set, late completion.
      force_dly = 20;
      want(0, 1'b0, AW'(20'h00040), '0);
      k = 0;
      while (!(owner >= 0 && n + 1 == t_issue + int'(TO)) && k < 100) begin
         step();
         k++;
      end
      clr_req = 1'b1;
      step();
      run_until_idle(100);
      chk("t5_sticky", 64'(err_timeout), 64'(1));
      clr_req = 1'b1;
      step();
      step();
      chk("t5_cleared", 64'(err_timeout), 64'(0));
      force_dly = -1;

      // Reset while port 1 is waiting on memory.
      force_dly = 10;
      want(1, 1'b0, AW'(20'h00050), '0);
      k = 0;
      while (!(owner == 1 && n == t_issue + 2) && k < 100) begin
         step();
         k++;
      end
      rst_req = 1'b1;
      step();
      repeat (15) step();
      force_dly = -1;
      want(0, 1'b0, AW'(20'h00060), '0);
      want(1, 1'b0, AW'(20'h00070), '0);
      base = glog.size();
      run_until_idle(100);
      chk("t6_grants", 64'(glog.size() - base), 64'(2));
      if (glog.size() - base == 2) chk("t6_first", 64'(glog[base]), 64'(0));
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", n);
      $fatal(1, "time limit");
   end

endmodule
